// File: rtl/jk_bank_arbiter_if.sv
// Requester-side command bus of the JK bank arbiter.
// The master drives req/cmd; the slave (arbiter) returns a one-hot grant.
interface jk_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    cmd_j;
  logic [NREQ-1:0]    cmd_k;
  logic [NREQ*AW-1:0] cmd_addr;
  logic [NREQ-1:0]    gnt;

  modport master (
    output req,
    output cmd_j,
    output cmd_k,
    output cmd_addr,
    input  gnt
  );

  modport slave (
    input  req,
    input  cmd_j,
    input  cmd_k,
    input  cmd_addr,
    output gnt
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that applies one granted JK command per cycle to a bank of JK flops.
// Grant is combinational in the request cycle; the q update lands on the transfer edge.
module jk_bank_arbiter #(
  parameter int   NREQ   = 4,
  parameter int   NFF    = 8,
  parameter int   AW     = 3,
  parameter logic Q_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_bank_arbiter_if.slave arb,
  output logic [NFF-1:0]   q,
  output logic [NREQ-1:0]  gnt_last,
  output logic             addr_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_rr_ptr;
  logic [NFF-1:0]  r_q;
  logic [NREQ-1:0] r_gnt_last;
  logic            r_addr_err;

  logic [NREQ-1:0] w_gnt;
  logic            w_xfer;
  logic            w_j;
  logic            w_k;
  logic [AW-1:0]   w_addr;
  logic [PW-1:0]   w_ptr_nxt;
  logic            w_addr_bad;
  logic [NFF-1:0]  w_q_nxt;

  // Search from r_rr_ptr upward with wrap; constant indices keep the mux width-clean.
  always_comb begin
    w_gnt     = '0;
    w_xfer    = 1'b0;
    w_j       = 1'b0;
    w_k       = 1'b0;
    w_addr    = '0;
    w_ptr_nxt = r_rr_ptr;
    if (rst_n) begin
      for (int off = 0; off < NREQ; off++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!w_xfer && (((int'(r_rr_ptr) + off) % NREQ) == i) && arb.req[i]) begin
            w_xfer    = 1'b1;
            w_gnt[i]  = 1'b1;
            w_j       = arb.cmd_j[i];
            w_k       = arb.cmd_k[i];
            w_addr    = arb.cmd_addr[i*AW +: AW];
            w_ptr_nxt = PW'((i + 1) % NREQ);
          end
        end
      end
    end
  end

  assign w_addr_bad = w_xfer && (int'(w_addr) >= NFF);

  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < NFF; i++) begin
      if (w_xfer && !w_addr_bad && (int'(w_addr) == i)) begin
        case ({w_j, w_k})
          2'b01:   w_q_nxt[i] = 1'b0;
          2'b10:   w_q_nxt[i] = 1'b1;
          2'b11:   w_q_nxt[i] = ~r_q[i];
          default: w_q_nxt[i] = r_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q        <= {NFF{Q_INIT}};
      r_rr_ptr   <= '0;
      r_gnt_last <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_q        <= w_q_nxt;
      r_gnt_last <= w_gnt;
      if (w_xfer) begin
        r_rr_ptr <= w_ptr_nxt;
      end
      // Out-of-range addresses still consume the grant so the pointer keeps rotating.
      if (w_addr_bad) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign arb.gnt  = w_gnt;
  assign q        = r_q;
  assign gnt_last = r_gnt_last;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Drives an 8-flop and a 6-flop arbiter with identical stimulus and checks both against a reference model.
module tb_jk_bank_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [7:0]      q_a;
  logic [5:0]      q_b;
  logic [NREQ-1:0] gl_a, gl_b;
  logic            err_a, err_b;

  jk_bank_arbiter_if #(.NREQ(NREQ), .NFF(8), .AW(AW)) ifa ();
  jk_bank_arbiter_if #(.NREQ(NREQ), .NFF(6), .AW(AW)) ifb ();

  jk_bank_arbiter #(.NREQ(NREQ), .NFF(8), .AW(AW), .Q_INIT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .arb(ifa.slave), .q(q_a), .gnt_last(gl_a), .addr_err(err_a)
  );
  jk_bank_arbiter #(.NREQ(NREQ), .NFF(6), .AW(AW), .Q_INIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .arb(ifb.slave), .q(q_b), .gnt_last(gl_b), .addr_err(err_b)
  );

  // Reference state: bits 0..5 of m_q are shared by both banks; only the 6-flop bank can raise an error.
  logic [7:0] m_q;
  int         m_ptr;
  logic [3:0] m_gl;
  logic       m_err_b;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_winner(input logic [3:0] rq);
    for (int off = 0; off < NREQ; off++) begin
      if (rq[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic step(input logic rst, input logic [3:0] rq, input logic [3:0] j,
                      input logic [3:0] k, input logic [11:0] ad);
    int         w;
    logic [3:0] g;
    int         a;
    @(negedge clk);
    rst_n = rst;
    ifa.req = rq; ifa.cmd_j = j; ifa.cmd_k = k; ifa.cmd_addr = ad;
    ifb.req = rq; ifb.cmd_j = j; ifb.cmd_k = k; ifb.cmd_addr = ad;
    #1;
    w = rst ? m_winner(rq) : -1;
    g = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    chk("gnt_a", {28'd0, ifa.gnt}, {28'd0, g});
    chk("gnt_b", {28'd0, ifb.gnt}, {28'd0, g});
    @(posedge clk);
    if (!rst) begin
      m_q = 8'h00; m_ptr = 0; m_gl = 4'b0; m_err_b = 1'b0;
    end else begin
      m_gl = g;
      if (w >= 0) begin
        a = int'(ad[w*AW +: AW]);
        case ({j[w], k[w]})
          2'b01:   m_q[a] = 1'b0;
          2'b10:   m_q[a] = 1'b1;
          2'b11:   m_q[a] = ~m_q[a];
          default: ;
        endcase
        if (a >= 6) m_err_b = 1'b1;
        m_ptr = (w + 1) % NREQ;
      end
    end
    #1;
    chk("q_a", {24'd0, q_a}, {24'd0, m_q});
    chk("q_b", {26'd0, q_b}, {26'd0, m_q[5:0]});
    chk("gnt_last_a", {28'd0, gl_a}, {28'd0, m_gl});
    chk("gnt_last_b", {28'd0, gl_b}, {28'd0, m_gl});
    chk("addr_err_a", {31'd0, err_a}, 32'd0);
    chk("addr_err_b", {31'd0, err_b}, {31'd0, m_err_b});
  endtask

  logic [1:0] t2_cmd [5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
  logic       t2_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int         t6_bits [4] = '{0, 2, 5, 7};

  initial begin
    rst_n = 1'b0;
    ifa.req = '0; ifa.cmd_j = '0; ifa.cmd_k = '0; ifa.cmd_addr = '0;
    ifb.req = '0; ifb.cmd_j = '0; ifb.cmd_k = '0; ifb.cmd_addr = '0;
    m_q = 8'h00; m_ptr = 0; m_gl = 4'b0; m_err_b = 1'b0;

    // T1 reset with all requests up
    step(1'b0, 4'hF, 4'hF, 4'h0, 12'h688);
    step(1'b0, 4'hF, 4'hF, 4'h0, 12'h688);
    chk("t1_q", {24'd0, q_a}, 32'h00);

    // T2 single requester on flop 3
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 4'b0001, {3'b0, t2_cmd[n][1]}, {3'b0, t2_cmd[n][0]}, 12'h003);
      chk("t2_q3", {31'd0, q_a[3]}, {31'd0, t2_exp[n]});
      chk("t2_rest", {24'd0, q_a & 8'hF7}, 32'h00);
    end

    // T3 full contention from a fresh pointer
    step(1'b0, 4'h0, 4'h0, 4'h0, 12'h000);
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 4'hF, 4'hF, 4'h0, 12'h688);
      if (n == 3) chk("t3_q", {24'd0, q_a}, 32'h0F);
    end

    // T4 wrap search from pointer 1, then from 0
    step(1'b1, 4'b1001, 4'h0, 4'h0, 12'h000);
    step(1'b1, 4'b1001, 4'h0, 4'h0, 12'h000);

    // T5 out-of-range address on the 6-flop bank via requester 2
    step(1'b1, 4'b0100, 4'b0100, 4'h0, 12'h1C0);
    chk("t5_err", {31'd0, err_b}, 32'd1);
    step(1'b1, 4'hF, 4'h0, 4'h0, 12'h000);
    chk("t5_err_sticky", {31'd0, err_b}, 32'd1);

    // T6 reset wins over a pending toggle
    step(1'b0, 4'h0, 4'h0, 4'h0, 12'h000);
    for (int n = 0; n < 4; n++) step(1'b1, 4'b0001, 4'b0001, 4'b0000, 12'(t6_bits[n]));
    chk("t6_pre", {24'd0, q_a}, 32'hA5);
    step(1'b0, 4'b0010, 4'b0010, 4'b0010, 12'h000);
    chk("t6_q", {24'd0, q_a}, 32'h00);
    step(1'b1, 4'b0010, 4'b0010, 4'b0010, 12'h000);
    chk("t6_after", {24'd0, q_a}, 32'h01);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 24) != 0), 4'($urandom), 4'($urandom), 4'($urandom), 12'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
